io_bus_controller: RTL and testbench

Memory-mapped bus controller sitting directly downstream of the CPU's memory port in the Simple RISC Machine top level. Decodes `mem_cmd`/`mem_addr` from the CPU, steers accesses to the 256-word RAM or to on-chip I/O registers, and returns read data with uniform one-cycle latency. I/O registers: LED register, synchronized switches, sticky switch-change register, free-running cycle counter, and a bus-error status flag.

---
 rtl/io_bus_controller_pkg.sv | 36 +++
 rtl/io_bus_controller_if.sv | 32 +++
 rtl/io_bus_controller_sw_sync.sv | 45 ++++
 rtl/io_bus_controller.sv | 115 +++++++++++
 tb/tb_io_bus_controller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/io_bus_controller_pkg.sv
// ============================================================================
// Module   : io_bus_controller_pkg
// Brief    : Shared command codes, I/O address map and read-select encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_bus_controller_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [ADDR_W-1:0] ADDR_LED  = 9'h100;
    localparam logic [ADDR_W-1:0] ADDR_SW   = 9'h140;
    localparam logic [ADDR_W-1:0] ADDR_CHG  = 9'h141;
    localparam logic [ADDR_W-1:0] ADDR_CNT  = 9'h142;
    localparam logic [ADDR_W-1:0] ADDR_STAT = 9'h143;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_IO   = 2'd2
    } rd_sel_e;

    function automatic logic is_io_reg(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_LED) || (addr == ADDR_SW) || (addr == ADDR_CHG) ||
               (addr == ADDR_CNT) || (addr == ADDR_STAT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_bus_controller_if.sv
// ============================================================================
// Module   : io_bus_controller_if
// Brief    : CPU memory-port and RAM-side bus bundle with CPU/controller views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_bus_controller_if;
    import io_bus_controller_pkg::*;

    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ram_write;
    logic [7:0]        ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output mem_cmd, mem_addr, write_data, ram_dout,
        input  read_data, ram_write, ram_addr, ram_din
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data, ram_dout,
        output read_data, ram_write, ram_addr, ram_din
    );

endinterface

`default_nettype wire

// File: rtl/io_bus_controller_sw_sync.sv
// ============================================================================
// Module   : io_bus_controller_sw_sync
// Brief    : Two-flop switch synchronizer with sticky per-bit change detect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_bus_controller_sw_sync (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [7:0] sw_i,
    input  wire logic       clr_i,
    output logic      [7:0] sw_sync_o,
    output logic      [7:0] chg_o
);

    logic [7:0] meta_q;
    logic [7:0] sync_q;
    logic [7:0] prev_q;
    logic [7:0] chg_q;
    logic [7:0] chg_d;

    // A change seen on the clearing edge survives the clear.
    assign chg_d = (clr_i ? 8'h00 : chg_q) | (sync_q ^ prev_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 8'h00;
            sync_q <= 8'h00;
            prev_q <= 8'h00;
            chg_q  <= 8'h00;
        end else begin
            meta_q <= sw_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            chg_q  <= chg_d;
        end
    end

    assign sw_sync_o = sync_q;
    assign chg_o     = chg_q;

endmodule

`default_nettype wire

// File: rtl/io_bus_controller.sv
// ============================================================================
// Module   : io_bus_controller
// Brief    : CPU memory-port decoder steering to RAM or on-chip I/O registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_bus_controller
    import io_bus_controller_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             reset,
    io_bus_controller_if.slave    bus,
    input  wire logic [7:0]       SW,
    output logic      [7:0]       LEDR,
    output logic                  bus_err
);

    logic              is_rd, is_wr, is_io_space;
    logic              chg_rd, chg_clr, err_set;
    logic [7:0]        sw_sync, chg;
    logic [7:0]        led_q;
    logic [15:0]       cnt_q;
    logic              err_q;
    logic              chg_rd_q;
    rd_sel_e           rd_sel_q, rd_sel_d;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;

    assign is_rd       = (bus.mem_cmd == MREAD);
    assign is_wr       = (bus.mem_cmd == MWRITE);
    assign is_io_space = bus.mem_addr[8];

    assign bus.ram_write = is_wr && !is_io_space;
    assign bus.ram_addr  = bus.mem_addr[7:0];
    assign bus.ram_din   = bus.write_data;

    // CPU holds a read for several cycles; only its first cycle clears CHG.
    assign chg_rd  = is_rd && (bus.mem_addr == ADDR_CHG);
    assign chg_clr = chg_rd && !chg_rd_q;
    assign err_set = (is_rd || is_wr) && is_io_space && !is_io_reg(bus.mem_addr);

    io_bus_controller_sw_sync u_sw_sync (
        .clk       (clk),
        .reset     (reset),
        .sw_i      (SW),
        .clr_i     (chg_clr),
        .sw_sync_o (sw_sync),
        .chg_o     (chg)
    );

    always_comb begin
        io_rdata_d = '0;
        case (bus.mem_addr)
            ADDR_LED:  io_rdata_d = {8'h00, led_q};
            ADDR_SW:   io_rdata_d = {8'h00, sw_sync};
            ADDR_CHG:  io_rdata_d = {8'h00, chg};
            ADDR_CNT:  io_rdata_d = cnt_q;
            ADDR_STAT: io_rdata_d = {15'h0000, err_q};
            default:   io_rdata_d = '0;
        endcase
    end

    always_comb begin
        rd_sel_d = SEL_NONE;
        if (is_rd) begin
            rd_sel_d = is_io_space ? SEL_IO : SEL_RAM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q      <= 8'h00;
            cnt_q      <= 16'h0000;
            err_q      <= 1'b0;
            chg_rd_q   <= 1'b0;
            rd_sel_q   <= SEL_NONE;
            io_rdata_q <= '0;
        end else begin
            chg_rd_q   <= chg_rd;
            rd_sel_q   <= rd_sel_d;
            io_rdata_q <= io_rdata_d;

            if (is_wr && (bus.mem_addr == ADDR_LED)) begin
                led_q <= bus.write_data[7:0];
            end

            if (is_wr && (bus.mem_addr == ADDR_CNT)) begin
                cnt_q <= 16'h0000;
            end else begin
                cnt_q <= cnt_q + 16'h0001;
            end

            if (err_set) begin
                err_q <= 1'b1;
            end else if (is_wr && (bus.mem_addr == ADDR_STAT)) begin
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.read_data = '0;
        case (rd_sel_q)
            SEL_RAM: bus.read_data = bus.ram_dout;
            SEL_IO:  bus.read_data = io_rdata_q;
            default: bus.read_data = '0;
        endcase
    end

    assign LEDR    = led_q;
    assign bus_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_controller.sv
// ============================================================================
// Module   : tb_io_bus_controller
// Brief    : Directed vector bench for io_bus_controller with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_bus_controller;
    import io_bus_controller_pkg::*;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [7:0]  exp_led;
        logic        exp_err;
        logic        exp_rw;
    } vec_t;

    localparam int NVEC = 20;

    logic        clk;
    logic        reset;
    logic [7:0]  SW;
    logic [7:0]  LEDR;
    logic        bus_err;
    int          n_chk;
    int          n_fail;
    logic [15:0] ram [256];
    vec_t        vecs [NVEC];

    io_bus_controller_if bus ();

    io_bus_controller dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .SW      (SW),
        .LEDR    (LEDR),
        .bus_err (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_write) ram[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ram[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wdata);
        @(negedge clk);
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wdata;
    endtask

    function automatic vec_t mk(input logic [1:0] cmd, input logic [8:0] addr,
                                input logic [15:0] wdata, input logic [15:0] rd,
                                input logic [7:0] led, input logic err, input logic rw);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.wdata = wdata;
        v.exp_rd = rd; v.exp_led = led; v.exp_err = err; v.exp_rw = rw;
        return v;
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        SW     = 8'h00;
        bus.mem_cmd    = MNONE;
        bus.mem_addr   = 9'h000;
        bus.write_data = 16'h0000;

        // Each record: inputs for one cycle, expected outputs seen early in that cycle.
        vecs[0]  = mk(MNONE,  9'h000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
        vecs[1]  = mk(MWRITE, 9'h100, 16'h0033, 16'h0000, 8'h00, 1'b0, 1'b0);
        vecs[2]  = mk(MREAD,  9'h100, 16'h0000, 16'h0000, 8'h33, 1'b0, 1'b0);
        vecs[3]  = mk(MNONE,  9'h000, 16'h0000, 16'h0033, 8'h33, 1'b0, 1'b0);
        vecs[4]  = mk(MWRITE, 9'h042, 16'h0033, 16'h0000, 8'h33, 1'b0, 1'b1);
        vecs[5]  = mk(MREAD,  9'h042, 16'h0000, 16'h0000, 8'h33, 1'b0, 1'b0);
        vecs[6]  = mk(MNONE,  9'h000, 16'h0000, 16'h0033, 8'h33, 1'b0, 1'b0);
        vecs[7]  = mk(MREAD,  9'h1A0, 16'h0000, 16'h0000, 8'h33, 1'b0, 1'b0);
        vecs[8]  = mk(MNONE,  9'h000, 16'h0000, 16'h0000, 8'h33, 1'b1, 1'b0);
        vecs[9]  = mk(MREAD,  9'h143, 16'h0000, 16'h0000, 8'h33, 1'b1, 1'b0);
        vecs[10] = mk(MWRITE, 9'h143, 16'h0000, 16'h0001, 8'h33, 1'b1, 1'b0);
        vecs[11] = mk(MWRITE, 9'h140, 16'h5555, 16'h0000, 8'h33, 1'b0, 1'b0);
        vecs[12] = mk(MREAD,  9'h100, 16'h0000, 16'h0000, 8'h33, 1'b0, 1'b0);
        vecs[13] = mk(MWRITE, 9'h100, 16'hABCD, 16'h0033, 8'h33, 1'b0, 1'b0);
        vecs[14] = mk(MWRITE, 9'h1FF, 16'h0000, 16'h0000, 8'hCD, 1'b0, 1'b0);
        vecs[15] = mk(MNONE,  9'h000, 16'h0000, 16'h0000, 8'hCD, 1'b1, 1'b0);
        vecs[16] = mk(MWRITE, 9'h0FF, 16'h1234, 16'h0000, 8'hCD, 1'b1, 1'b1);
        vecs[17] = mk(MWRITE, 9'h143, 16'h0000, 16'h0000, 8'hCD, 1'b1, 1'b0);
        vecs[18] = mk(MREAD,  9'h0FF, 16'h0000, 16'h0000, 8'hCD, 1'b0, 1'b0);
        vecs[19] = mk(MNONE,  9'h000, 16'h0000, 16'h1234, 8'hCD, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset read_data", bus.read_data, 16'h0000);
        chk("reset LEDR", {8'h00, LEDR}, 16'h0000);
        chk("reset bus_err", {15'h0, bus_err}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("vec%0d read_data", i), bus.read_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d LEDR", i), {8'h00, LEDR}, {8'h00, vecs[i].exp_led});
            chk($sformatf("vec%0d bus_err", i), {15'h0, bus_err}, {15'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d ram_write", i), {15'h0, bus.ram_write}, {15'h0, vecs[i].exp_rw});
            chk($sformatf("vec%0d ram_addr", i), {8'h00, bus.ram_addr}, {8'h00, vecs[i].addr[7:0]});
        end

        // Switch synchronizer, then CHG read held three cycles.
        drive(MNONE, 9'h000, 16'h0000);
        SW = 8'h35;
        drive(MNONE, 9'h000, 16'h0000);
        drive(MNONE, 9'h000, 16'h0000);
        drive(MREAD, 9'h140, 16'h0000);
        drive(MREAD, 9'h141, 16'h0000);
        #1 chk("sw read", bus.read_data, 16'h0035);
        drive(MREAD, 9'h141, 16'h0000);
        #1 chk("chg first read", bus.read_data, 16'h0035);
        drive(MREAD, 9'h141, 16'h0000);
        #1 chk("chg held read", bus.read_data, 16'h0000);
        drive(MNONE, 9'h000, 16'h0000);
        #1 chk("chg held read 2", bus.read_data, 16'h0000);
        drive(MREAD, 9'h141, 16'h0000);
        drive(MNONE, 9'h000, 16'h0000);
        #1 chk("chg reread", bus.read_data, 16'h0000);

        // SW[0] change lands on the clearing edge of a fresh CHG read.
        drive(MNONE, 9'h000, 16'h0000);
        SW = 8'h34;
        drive(MNONE, 9'h000, 16'h0000);
        drive(MREAD, 9'h141, 16'h0000);
        drive(MREAD, 9'h141, 16'h0000);
        #1 chk("chg race first", bus.read_data, 16'h0000);
        drive(MREAD, 9'h141, 16'h0000);
        #1 chk("chg race kept", bus.read_data, 16'h0001);
        drive(MNONE, 9'h000, 16'h0000);
        #1 chk("chg race held", bus.read_data, 16'h0001);
        drive(MREAD, 9'h141, 16'h0000);
        drive(MNONE, 9'h000, 16'h0000);
        #1 chk("chg race clr read", bus.read_data, 16'h0001);
        drive(MREAD, 9'h141, 16'h0000);
        drive(MNONE, 9'h000, 16'h0000);
        #1 chk("chg race cleared", bus.read_data, 16'h0000);

        // Counter: clear, then read four idle cycles later.
        drive(MWRITE, 9'h142, 16'hBEEF);
        repeat (4) drive(MNONE, 9'h000, 16'h0000);
        drive(MREAD, 9'h142, 16'h0000);
        drive(MNONE, 9'h000, 16'h0000);
        #1 chk("cnt after 4", bus.read_data, 16'h0004);

        // Counter wrap at 0xFFFF.
        drive(MWRITE, 9'h142, 16'h0000);
        drive(MNONE, 9'h000, 16'h0000);
        repeat (65534) @(negedge clk);
        drive(MREAD, 9'h142, 16'h0000);
        drive(MREAD, 9'h142, 16'h0000);
        #1 chk("cnt ffff", bus.read_data, 16'hFFFF);
        drive(MNONE, 9'h000, 16'h0000);
        #1 chk("cnt wrap", bus.read_data, 16'h0000);

        // Reset asserted during an LED write.
        drive(MREAD, 9'h100, 16'h0000);
        drive(MWRITE, 9'h100, 16'h00AA);
        #1 chk("led before reset", bus.read_data, 16'h00CD);
        #1 reset = 1'b0;
        #1 chk("reset mid LEDR", {8'h00, LEDR}, 16'h0000);
        chk("reset mid read_data", bus.read_data, 16'h0000);
        drive(MNONE, 9'h000, 16'h0000);
        reset = 1'b1;
        drive(MNONE, 9'h000, 16'h0000);
        #1 chk("post reset LEDR", {8'h00, LEDR}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
